// File: rtl/axis_1553_pkg.sv
// Shared definitions for the MIL-STD-1553 AXI-Stream message encoder:
// sync/diff codes, tuser field positions, FSM states and the word pattern builder.
package axis_1553_pkg;

    localparam logic [1:0] SYNC_CMD  = 2'b01;
    localparam logic [1:0] SYNC_DATA = 2'b10;

    localparam logic [1:0] DIFF_HIGH = 2'b10;
    localparam logic [1:0] DIFF_LOW  = 2'b01;
    localparam logic [1:0] DIFF_IDLE = 2'b00;

    localparam int TUSER_SYNC_LSB = 0;
    localparam int TUSER_BUS      = 2;
    localparam int TUSER_PINV     = 3;

    localparam int WORD_HALF_BITS = 40;
    localparam int BEAT_W         = 25;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TX   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Line level per half-bit, bit 39 transmitted first (1 = high, 0 = low).
    function automatic logic [39:0] build_pattern(
        input logic [15:0] data,
        input logic        is_cmd,
        input logic        pinv
    );
        logic [39:0] pat;
        logic        par;
        pat[39:34] = is_cmd ? 6'b111000 : 6'b000111;
        for (int i = 0; i < 16; i++) begin
            pat[33 - 2*i] = data[15 - i];
            pat[32 - 2*i] = ~data[15 - i];
        end
        par    = ~(^data) ^ pinv;
        pat[1] = par;
        pat[0] = ~par;
        return pat;
    endfunction

endpackage

// File: rtl/axis_1553_word_fifo.sv
// Beat buffer for the 1553 encoder: pointer-based FIFO with a registered
// ready flag and a fall-through read so a freshly written beat can be loaded next cycle.
module axis_1553_word_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             ready,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("axis_1553_word_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg, wr_ptr_next;
    logic [AW:0]      rd_ptr_reg, rd_ptr_next;
    logic             ready_reg;
    logic             push, pop, full_next;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign push    = wr_valid && ready_reg;
    assign pop     = rd_en && !empty;
    assign ready   = ready_reg;
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    always_comb begin
        wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, push};
        rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop};
        full_next   = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                      (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
    end

    // ready is held low through reset and then mirrors !full exactly,
    // so a push while full is never accepted even if a pop happens that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            ready_reg  <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            ready_reg  <= !full_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/axis_1553_encoder_msg.sv
// MIL-STD-1553 Manchester II message encoder fed by AXI-Stream words;
// drives one of two buses per message and enforces an inter-message idle gap.
module axis_1553_encoder_msg
    import axis_1553_pkg::*;
#(
    parameter int CLOCK_SPEED   = 20000000,
    parameter int BIT_RATE      = 1000000,
    parameter int FIFO_DEPTH    = 16,
    parameter int GAP_HALF_BITS = 8
) (
    input  logic        aclk,
    input  logic        arstn,
    input  logic [15:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tuser,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [1:0]  diff_a,
    output logic [1:0]  diff_b,
    output logic        en_diff_a,
    output logic        en_diff_b,
    output logic        busy,
    output logic        underrun
);

    localparam int HALF       = CLOCK_SPEED / (2 * BIT_RATE);
    localparam int CNT_W      = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int GAP_CYCLES = GAP_HALF_BITS * HALF;
    localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    if (HALF * 2 * BIT_RATE != CLOCK_SPEED || HALF < 2) begin : g_bad_rate
        $error("axis_1553_encoder_msg: CLOCK_SPEED must be an exact multiple of 2*BIT_RATE with H >= 2");
    end
    if (GAP_HALF_BITS < 1) begin : g_bad_gap
        $error("axis_1553_encoder_msg: GAP_HALF_BITS must be at least 1");
    end

    logic [BEAT_W-1:0] beat, fifo_data;
    logic              fifo_empty, fifo_pop;
    logic              fifo_last;
    logic [7:0]        fifo_user;
    logic [15:0]       fifo_word;
    logic [39:0]       load_pat;
    logic              unused_user_bits;

    assign beat = {s_axis_tlast, s_axis_tuser, s_axis_tdata};

    axis_1553_word_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (aclk),
        .rst_n    (arstn),
        .wr_valid (s_axis_tvalid),
        .wr_data  (beat),
        .ready    (s_axis_tready),
        .rd_en    (fifo_pop),
        .rd_data  (fifo_data),
        .empty    (fifo_empty)
    );

    assign fifo_last        = fifo_data[24];
    assign fifo_user        = fifo_data[23:16];
    assign fifo_word        = fifo_data[15:0];
    assign unused_user_bits = ^fifo_user[7:4];
    assign load_pat         = build_pattern(fifo_word,
                                            fifo_user[TUSER_SYNC_LSB +: 2] == SYNC_CMD,
                                            fifo_user[TUSER_PINV]);

    state_t            state_reg, state_next;
    logic [39:0]       pat_reg, pat_next;
    logic [5:0]        half_reg, half_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [GAP_W-1:0]  gap_reg, gap_next;
    logic              last_reg, last_next;
    logic              bus_reg, bus_next;
    logic [1:0]        diff_a_reg, diff_a_next;
    logic [1:0]        diff_b_reg, diff_b_next;
    logic              en_a_reg, en_a_next;
    logic              en_b_reg, en_b_next;
    logic              busy_reg, busy_next;
    logic              underrun_reg, underrun_next;
    logic [1:0]        tx_code;

    assign tx_code = pat_reg[39] ? DIFF_HIGH : DIFF_LOW;

    // Outputs are computed one cycle ahead and registered, so the level shown
    // for a half-bit lags the counters by one clock; the word-end edge therefore
    // still drives the final parity clock while loading the next word.
    always_comb begin
        state_next    = state_reg;
        pat_next      = pat_reg;
        half_next     = half_reg;
        cnt_next      = cnt_reg;
        gap_next      = gap_reg;
        last_next     = last_reg;
        bus_next      = bus_reg;
        diff_a_next   = DIFF_IDLE;
        diff_b_next   = DIFF_IDLE;
        en_a_next     = 1'b0;
        en_b_next     = 1'b0;
        busy_next     = busy_reg;
        underrun_next = 1'b0;
        fifo_pop      = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    pat_next   = load_pat;
                    last_next  = fifo_last;
                    bus_next   = fifo_user[TUSER_BUS];
                    half_next  = '0;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                    state_next = ST_TX;
                end
            end

            ST_TX: begin
                if (bus_reg) begin
                    diff_b_next = tx_code;
                    en_b_next   = 1'b1;
                end else begin
                    diff_a_next = tx_code;
                    en_a_next   = 1'b1;
                end

                if (cnt_reg == CNT_W'(HALF - 1)) begin
                    cnt_next = '0;
                    if (half_reg == 6'(WORD_HALF_BITS - 1)) begin
                        if (last_reg) begin
                            state_next = ST_GAP;
                            gap_next   = '0;
                        end else if (!fifo_empty) begin
                            fifo_pop  = 1'b1;
                            pat_next  = load_pat;
                            last_next = fifo_last;
                            half_next = '0;
                        end else begin
                            state_next    = ST_GAP;
                            gap_next      = '0;
                            underrun_next = 1'b1;
                        end
                    end else begin
                        half_next = half_reg + 6'd1;
                        pat_next  = {pat_reg[38:0], 1'b0};
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_GAP: begin
                if (gap_reg == GAP_W'(GAP_CYCLES - 1)) begin
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_reg    <= ST_IDLE;
            pat_reg      <= '0;
            half_reg     <= '0;
            cnt_reg      <= '0;
            gap_reg      <= '0;
            last_reg     <= 1'b0;
            bus_reg      <= 1'b0;
            diff_a_reg   <= DIFF_IDLE;
            diff_b_reg   <= DIFF_IDLE;
            en_a_reg     <= 1'b0;
            en_b_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pat_reg      <= pat_next;
            half_reg     <= half_next;
            cnt_reg      <= cnt_next;
            gap_reg      <= gap_next;
            last_reg     <= last_next;
            bus_reg      <= bus_next;
            diff_a_reg   <= diff_a_next;
            diff_b_reg   <= diff_b_next;
            en_a_reg     <= en_a_next;
            en_b_reg     <= en_b_next;
            busy_reg     <= busy_next;
            underrun_reg <= underrun_next;
        end
    end

    assign diff_a    = diff_a_reg;
    assign diff_b    = diff_b_reg;
    assign en_diff_a = en_a_reg;
    assign en_diff_b = en_b_reg;
    assign busy      = busy_reg;
    assign underrun  = underrun_reg;

endmodule
